// File: rtl/cordic_wb_driver.sv
// Wishbone slave that clocks byte streams into a slow user core
// and collects its result bytes.
module cordic_wb_driver #(
  parameter int          CLK_DIV  = 4,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        dut_clk_o,
  output logic        dut_rst_o,
  output logic [7:0]  dut_data_o,
  input  logic [7:0]  dut_data_i,
  output logic        irq_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RECV = 2'd3;

  localparam logic [7:0] DIV_TOP = 8'(CLK_DIV - 1);

  logic        r_ack;
  logic [31:0] r_dat;
  logic [1:0]  r_state;
  logic [7:0]  r_div;
  logic        r_clk;
  logic [7:0]  r_data;
  logic [7:0]  r_cnt;
  logic        r_rst;
  logic [2:0]  r_nin;
  logic [2:0]  r_nout;
  logic [7:0]  r_wait;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_done;
  logic [7:0]  r_txn;

  logic        w_req;
  logic        w_hit;
  logic [1:0]  w_reg;
  logic        w_wr;
  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_tx_wr;
  logic        w_st_wr;
  logic        w_start;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic [2:0]  w_nin;
  logic [2:0]  w_nout;
  logic        w_last;
  logic        w_done_evt;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^wbs_adr_i[1:0];

  assign w_req  = wbs_stb_i & wbs_cyc_i;
  assign w_hit  = wbs_adr_i[31:4] == BASE_ADR[31:4];
  assign w_reg  = wbs_adr_i[3:2];
  assign w_wr   = r_ack & w_req & wbs_we_i & w_hit;
  assign w_busy = r_state != S_IDLE;

  assign w_ctrl_wr = w_wr & (w_reg == 2'd0) & ~w_busy;
  assign w_tx_wr   = w_wr & (w_reg == 2'd1) & ~w_busy;
  assign w_st_wr   = w_wr & (w_reg == 2'd3);
  assign w_start   = w_ctrl_wr & wbs_sel_i[0] & wbs_dat_i[0];

  assign w_tick = w_busy & (r_div == DIV_TOP);
  assign w_rise = w_tick & ~r_clk;
  assign w_fall = w_tick & r_clk;

  // Zero and out-of-range counts both mean a full four bytes
  assign w_nin  = (r_nin == 3'd0 || r_nin > 3'd4) ? 3'd4 : r_nin;
  assign w_nout = (r_nout == 3'd0 || r_nout > 3'd4) ? 3'd4 : r_nout;

  assign w_last     = r_cnt == ({5'd0, w_nout} - 8'd1);
  assign w_done_evt = (r_state == S_RECV) & w_fall & w_last;

  always_comb begin
    w_rdata = 32'h0;
    if (w_hit) begin
      case (w_reg)
        2'd0: w_rdata = {8'h0, r_wait, 1'b0, r_nout,
                         1'b0, r_nin, 6'h0, r_rst, 1'b0};
        2'd1: w_rdata = r_tx;
        2'd2: w_rdata = r_rx;
        default: w_rdata = {16'h0, r_txn, 6'h0, r_done, w_busy};
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_req & ~r_ack;
      r_dat <= (w_req & ~r_ack) ? w_rdata : 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rst  <= 1'b0;
      r_nin  <= 3'd0;
      r_nout <= 3'd0;
      r_wait <= 8'd0;
      r_tx   <= 32'h0;
    end else begin
      if (w_ctrl_wr) begin
        if (wbs_sel_i[0]) r_rst <= wbs_dat_i[1];
        if (wbs_sel_i[1]) begin
          r_nin  <= wbs_dat_i[10:8];
          r_nout <= wbs_dat_i[14:12];
        end
        if (wbs_sel_i[2]) r_wait <= wbs_dat_i[23:16];
      end
      if (w_tx_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) r_tx[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Completion wins over a same-cycle write-1-to-clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_done <= 1'b0;
      r_txn  <= 8'd0;
    end else if (w_done_evt) begin
      r_done <= 1'b1;
      r_txn  <= r_txn + 8'd1;
    end else if (w_start) begin
      r_done <= 1'b0;
    end else if (w_st_wr & wbs_sel_i[0] & wbs_dat_i[1]) begin
      r_done <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_div   <= 8'd0;
      r_clk   <= 1'b0;
      r_data  <= 8'd0;
      r_cnt   <= 8'd0;
      r_rx    <= 32'h0;
    end else if (r_state == S_IDLE) begin
      r_div  <= 8'd0;
      r_clk  <= 1'b0;
      r_cnt  <= 8'd0;
      r_data <= 8'd0;
      if (w_start) begin
        r_state <= S_SEND;
        r_data  <= r_tx[7:0];
        r_rx    <= 32'h0;
      end
    end else begin
      if (w_tick) begin
        r_div <= 8'd0;
        r_clk <= ~r_clk;
      end else begin
        r_div <= r_div + 8'd1;
      end
      case (r_state)
        S_SEND: begin
          if (w_rise) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (w_fall) begin
            if (r_cnt < {5'd0, w_nin}) begin
              r_data <= r_tx[{r_cnt[1:0], 3'b000} +: 8];
            end else begin
              r_data  <= 8'd0;
              r_cnt   <= 8'd0;
              r_state <= (r_wait == 8'd0) ? S_RECV : S_WAIT;
            end
          end
        end
        // Leave WAIT on a fall so every RECV fall follows a RECV rise
        S_WAIT: begin
          if (w_rise) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (w_fall && r_cnt == r_wait) begin
            r_cnt   <= 8'd0;
            r_state <= S_RECV;
          end
        end
        default: begin
          if (w_fall) begin
            r_rx[{r_cnt[1:0], 3'b000} +: 8] <= dut_data_i;
            if (w_last) begin
              r_cnt   <= 8'd0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign dut_clk_o  = r_clk;
  assign dut_rst_o  = r_rst;
  assign dut_data_o = r_data;
  assign irq_o      = r_done;

endmodule

// File: tb/tb_cordic_wb_driver.sv
// Directed bench for cordic_wb_driver: register table plus
// hand-written transaction sequences against a counting core model.
module tb_cordic_wb_driver;

  localparam int CD = 2;
  localparam logic [31:0] B    = 32'h3000_0000;
  localparam logic [31:0] A_CT = B;
  localparam logic [31:0] A_TX = B + 32'h4;
  localparam logic [31:0] A_RX = B + 32'h8;
  localparam logic [31:0] A_ST = B + 32'hC;
  localparam logic [31:0] A_NA = B + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = 32'h0;
  logic [31:0] adr = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        dclk;
  logic        drst;
  logic [7:0]  ddo;
  logic [7:0]  ddi;
  logic        irq;

  int checks = 0;
  int failures = 0;

  int          core_rises = 0;
  int          rise_base = 0;
  bit          core_mode = 1'b0;
  logic [7:0]  rise_data [64];
  logic        rst_at_ack;
  logic        irq_at_ack;

  cordic_wb_driver #(.CLK_DIV(CD), .BASE_ADR(B)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .dut_clk_o (dclk),
    .dut_rst_o (drst),
    .dut_data_o(ddo),
    .dut_data_i(ddi),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  // Core model: records the input byte at each rise, returns C0+rises
  always @(posedge dclk) begin
    rise_data[core_rises % 64] <= ddo;
    core_rises <= core_rises + 1;
  end

  assign ddi = core_mode ? 8'(32'hC0 + core_rises - rise_base)
                         : 8'h3C;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [31:0] a,
                    input logic [3:0] s, input logic [31:0] d,
                    output logic [31:0] r);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; wdat = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 20);
    r = rdat;
    rst_at_ack = drst;
    irq_at_ack = irq;
    chk("wb_ack", {31'h0, ack}, 32'h1);
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, a, 4'hF, d, r);
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, a, 4'hF, 32'h0, r);
    chk(name, r, exp);
  endtask

  task automatic wait_done(output int cyc_n);
    cyc_n = 0;
    while (!irq && cyc_n < 2000) begin
      @(posedge clk); #1;
      cyc_n++;
    end
    if (!irq) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got irq 0 expected 1");
    end
  endtask

  function automatic logic [7:0] rbyte(input int k);
    return rise_data[(rise_base + k) % 64];
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int          cyc_n;
    logic [31:0] r;

    tbl[0]  = '{1'b1, A_TX, 4'hF, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b0, A_TX, 4'hF, 32'h0, 32'h1234_5678};
    tbl[2]  = '{1'b1, A_TX, 4'h1, 32'hFFFF_FFFF, 32'h0};
    tbl[3]  = '{1'b0, A_TX, 4'hF, 32'h0, 32'h1234_56FF};
    tbl[4]  = '{1'b1, A_CT, 4'hF, 32'h00AB_3402, 32'h0};
    tbl[5]  = '{1'b0, A_CT, 4'hF, 32'h0, 32'h00AB_3402};
    tbl[6]  = '{1'b1, A_CT, 4'h3, 32'h00FF_0000, 32'h0};
    tbl[7]  = '{1'b0, A_CT, 4'hF, 32'h0, 32'h00AB_0000};
    tbl[8]  = '{1'b1, A_NA, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1'b0, A_NA, 4'hF, 32'h0, 32'h0};
    tbl[10] = '{1'b1, A_RX, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{1'b0, A_RX, 4'hF, 32'h0, 32'h0};
    tbl[12] = '{1'b0, A_TX, 4'hF, 32'h0, 32'h1234_56FF};
    tbl[13] = '{1'b0, A_ST, 4'hF, 32'h0, 32'h0};
    tbl[14] = '{1'b1, A_CT, 4'hF, 32'h0, 32'h0};
    tbl[15] = '{1'b0, A_CT, 4'hF, 32'h0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {22'h0, ack, dclk, drst, irq, ddo},
        32'h0);
    chk("reset_rdat", rdat, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("reset_status", A_ST, 32'h0);

    for (int i = 0; i < 16; i++) begin
      wb(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, r);
      if (!tbl[i].we) chk($sformatf("tbl_%0d", i), r, tbl[i].exp);
    end

    // Reset during SEND
    wr(A_TX, 32'h4433_2211);
    rise_base = core_rises;
    wr(A_CT, 32'h0000_0003);
    chk("midsend_data", {24'h0, ddo}, 32'h11);
    chk("midsend_rst", {31'h0, drst}, 32'h1);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midsend_abort", {22'h0, ack, dclk, drst, irq, ddo}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd("abort_status", A_ST, 32'h0);
    rd("abort_ctrl", A_CT, 32'h0);
    rd("abort_tx", A_TX, 32'h0);

    // Basic transaction
    wr(A_TX, 32'h0000_A55A);
    core_mode = 1'b0;
    rise_base = core_rises;
    wr(A_CT, 32'h0001_1201);
    wait_done(cyc_n);
    chk("basic_latency", 32'(cyc_n), 32'd16);
    chk("basic_rise1", {24'h0, rbyte(0)}, 32'h5A);
    chk("basic_rise2", {24'h0, rbyte(1)}, 32'hA5);
    rd("basic_rx", A_RX, 32'h0000_003C);
    rd("basic_status", A_ST, 32'h0000_0102);
    chk("basic_irq", {31'h0, irq}, 32'h1);

    wr(A_ST, 32'h0000_0002);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    rd("w1c_status", A_ST, 32'h0000_0100);

    // Busy protection
    wr(A_TX, 32'h4433_2211);
    core_mode = 1'b1;
    rise_base = core_rises;
    wr(A_CT, 32'h0000_1401);
    wr(A_TX, 32'hFFFF_FFFF);
    wr(A_CT, 32'h0000_0001);
    wait_done(cyc_n);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy_rise%0d", k + 1), {24'h0, rbyte(k)},
          32'(8'h11 * (k + 1)));
    end
    rd("busy_tx", A_TX, 32'h4433_2211);
    rd("busy_ctrl", A_CT, 32'h0000_1400);
    rd("busy_rx", A_RX, 32'h0000_00C5);
    rd("busy_status", A_ST, 32'h0000_0202);

    // All-zero encodings: 4 in, no wait, 4 out
    rise_base = core_rises;
    wr(A_CT, 32'h0000_0001);
    wait_done(cyc_n);
    chk("zero_latency", 32'(cyc_n), 32'd32);
    chk("zero_rise4", {24'h0, rbyte(3)}, 32'h44);
    chk("zero_rise5", {24'h0, rbyte(4)}, 32'h00);
    rd("zero_rx", A_RX, 32'hC8C7_C6C5);

    // Completion and W1C on the same edge
    rise_base = core_rises;
    wr(A_CT, 32'h0000_1101);
    repeat (6) begin @(posedge clk); #1; end
    wr(A_ST, 32'h0000_0002);
    chk("same_irq_before", {31'h0, irq_at_ack}, 32'h0);
    chk("same_irq_after", {31'h0, irq}, 32'h1);
    rd("same_rx", A_RX, 32'h0000_00C2);
    rd("same_status", A_ST, 32'h0000_0402);

    wr(A_CT, 32'h0000_0002);
    chk("rst_at_ack", {31'h0, rst_at_ack}, 32'h0);
    chk("rst_after", {31'h0, drst}, 32'h1);
    wr(A_CT, 32'h0000_0000);

    // Counter wrap
    for (int t = 5; t <= 256; t++) begin
      wr(A_CT, 32'h0000_1101);
      wait_done(cyc_n);
      if (t == 255) rd("cnt_255", A_ST, 32'h0000_FF02);
    end
    rd("cnt_wrap", A_ST, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
